// File: rtl/pipe_adder.sv
// pipe_adder -- ripple-carry adder split into STAGES pipelined slices.
//
// Each stage adds one SEG = WIDTH/STAGES bit slice and passes its carry to the
// next stage, so the carry ripples one slice per clock. A single global
// "advance" (output empty or being consumed) shifts every stage at once, so
// a stalled output freezes the whole pipe, bubbles included.
//
// Parameters: WIDTH (operand/sum bits, multiple of STAGES), STAGES (>= 1).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a, b, c, in_valid     operands, carry-in, request valid
//   in_ready              operation accepted this cycle (== advance)
//   sum, c_out, out_valid {c_out,sum} = a+b+c, result valid
//   out_ready             downstream consumes the result
//   ovf                   signed overflow (only with PIPE_ADDER_OVF_EN)
// Optional feature macro: PIPE_ADDER_OVF_EN.

module pipe_adder_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;
  // Unadded B bits shrink by SEG per stage; they live back to back in b_flat.
  // Stage k (k >= 1) reads WIDTH-k*SEG bits at offset (k-1)*WIDTH - SEG*(k-1)*k/2.
  localparam int B_TOT = (STAGES - 1) * WIDTH - SEG * (STAGES - 1) * STAGES / 2;
  localparam int B_W   = (B_TOT > 0) ? B_TOT : 1;

  logic                         advance;
  logic [STAGES:0]              vld_pipe;
  // acc holds finished sum bits at the top and unadded A bits at the bottom;
  // each stage shifts right by SEG and inserts its slice sum at the top.
  logic [STAGES:0][WIDTH-1:0]   acc_pipe;
  logic [STAGES:0]              cy_pipe;
  logic [B_W-1:0]               b_flat;

  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance;

  assign vld_pipe[0] = in_valid;
  assign acc_pipe[0] = a;
  assign cy_pipe[0]  = c;

  assign out_valid   = vld_pipe[STAGES];
  assign sum         = acc_pipe[STAGES];
  assign c_out       = cy_pipe[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BW    = WIDTH - k * SEG;
    localparam int B_OFF = (k - 1) * WIDTH - SEG * (k - 1) * k / 2;
    localparam int N_OFF = k * WIDTH - SEG * k * (k + 1) / 2;

    logic [BW-1:0]    b_i;
    logic [SEG-1:0]   s;
    logic             co;
    logic             v_r;
    logic             c_r;
    logic [WIDTH-1:0] acc_r;

    if (k == 0) begin : g_b_in
      assign b_i = b;
    end else begin : g_b_pipe
      assign b_i = b_flat[B_OFF +: BW];
    end

    pipe_adder_slice #(.SEG(SEG)) u_slice (
      .a  (acc_pipe[k][SEG-1:0]),
      .b  (b_i[SEG-1:0]),
      .ci (cy_pipe[k]),
      .s  (s),
      .co (co)
    );

    // Data only loads with a valid op so idle operands never reach outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        acc_r <= '0;
      end else if (advance) begin
        v_r <= vld_pipe[k];
        if (vld_pipe[k]) begin
          c_r   <= co;
          acc_r <= (acc_pipe[k] >> SEG) | (WIDTH'(s) << (WIDTH - SEG));
        end
      end
    end

    assign vld_pipe[k+1] = v_r;
    assign acc_pipe[k+1] = acc_r;
    assign cy_pipe[k+1]  = c_r;

    if (k < STAGES - 1) begin : g_b_reg
      logic [BW-SEG-1:0] b_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     b_r <= '0;
        else if (advance && vld_pipe[k]) b_r <= b_i[BW-1:SEG];
      end
      assign b_flat[N_OFF +: BW-SEG] = b_r;
    end

`ifdef PIPE_ADDER_OVF_EN
    // The last stage sees the operand MSB slices and produces the sum MSB,
    // so overflow is formed here and stays aligned with its result.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_r <= 1'b0;
        else if (advance) ovf_r <= vld_pipe[k] &&
                                   (acc_pipe[k][SEG-1] == b_i[SEG-1]) &&
                                   (s[SEG-1] != acc_pipe[k][SEG-1]);
      end
      assign ovf = ovf_r;
    end
`endif
  end
endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, sum;
  logic        c, in_valid, in_ready, c_out, out_valid, out_ready;
`ifdef PIPE_ADDER_OVF_EN
  logic        ovf;
`endif

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [17:0] sb[$];          // {ovf, c_out, sum}
  logic [17:0] e;
  logic [15:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        gap_en = 1'b0;
  int          n_phase = 0;
  int          prev_cyc = 0;
  logic        rnd_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] model(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    logic [16:0] r;
    r = {1'b0, xa} + {1'b0, xb} + {16'b0, xc};
    return {(xa[15] == xb[15]) && (r[15] != xa[15]), r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a result is consumed on the edge after a negedge where
  // out_valid && out_ready, so compare it here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e[15:0]));
        check("c_out", 32'(c_out), 32'(e[16]));
`ifdef PIPE_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e[17]));
`endif
        last_sum  = e[15:0];
        last_cout = e[16];
        if (gap_en && n_phase > 0) check("b2b_gap", 32'(cyc - prev_cyc), 32'd1);
        prev_cyc = cyc;
        n_phase++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, output int waits);
    a = xa; b = xb; c = xc; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready) sb.push_back(model(xa, xb, xc));
    else check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    int cnt;
    a = '0; b = '0; c = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    rst_n = 1'b1;

    // Full carry ripple and latency
    send(16'hFFFF, 16'h0001, 1'b0, w);
    check("first_accept", 32'(w), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("latency_%0d", k), 32'(out_valid), 32'(k == 3));
    end
    @(posedge clk);
    #1;
    drain();

    send(16'hFFFF, 16'hFFFF, 1'b1, w);
    send(16'h0000, 16'h0000, 1'b0, w);
    drain();

    // Back-to-back: 8 consecutive results
    gap_en = 1'b1;
    n_phase = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'(2 * i), i[0], w);
      check("b2b_accept", 32'(w), 32'd0);
    end
    drain();
    gap_en = 1'b0;
    check("b2b_count", 32'(n_phase), 32'd8);

    // Stall with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1'b1, w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(sb[0][15:0]));
      check("hold_c_out", 32'(c_out), 32'(sb[0][16]));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'hABCD, 16'h1234, 1'b0, w);
    drain();

    // Reset with 3 ops in flight
    send(16'h0101, 16'h0202, 1'b0, w);
    send(16'h0303, 16'h0404, 1'b1, w);
    send(16'h0505, 16'h0606, 1'b0, w);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'h4321, 16'h1111, 1'b1, w);
    check("post_rst_accept", 32'(w), 32'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_results", 32'(cnt), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Random traffic with bubbles and random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        a = 16'($urandom); b = 16'($urandom);
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), w);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Idle operands must not disturb outputs
    repeat (5) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_sum", 32'(sum), 32'(last_sum));
      check("idle_c_out", 32'(c_out), 32'(last_cout));
`ifdef PIPE_ADDER_OVF_EN
      check("idle_ovf", 32'(ovf), 32'd0);
`endif
      @(posedge clk);
      #1;
    end

`ifdef PIPE_ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0, w);
    send(16'h8000, 16'hFFFF, 1'b0, w);
    send(16'h0001, 16'h0001, 1'b0, w);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline stage count; WIDTH SHALL be an integer multiple of STAGES, and STAGES >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  WIDTH  operand A, unsigned (two's complement when overflow detection is compiled in).
REQ-006 b  input  WIDTH  operand B.
REQ-007 c  input  1  carry-in.
REQ-008 in_valid  input  1  a/b/c carry a valid operation.
REQ-009 in_ready  output  1  block accepts an operation this cycle.
REQ-010 sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+c.
REQ-011 c_out  output  1  carry-out of bit WIDTH-1.
REQ-012 out_valid  output  1  sum/c_out hold a valid result.
REQ-013 out_ready  input  1  downstream consumes the result this cycle.
REQ-014 ovf  output  1  signed overflow flag; present only per REQ-030.

Function
REQ-015 Datapath SHALL be a ripple-carry adder split into STAGES slices of SEG = WIDTH/STAGES bits; slice k SHALL compute bits [k*SEG+SEG-1 : k*SEG] in stage k.
REQ-016 Each stage SHALL register its carry-out, the completed lower sum bits, and the not-yet-added upper operand bits; the carry SHALL propagate one slice per stage.
REQ-017 Transfer rule: an operation is accepted on a rising edge where in_valid=1 and in_ready=1; a result is consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-018 advance = !out_valid | out_ready; all stages SHALL shift by one exactly when advance=1 and hold all contents otherwise.
REQ-019 in_ready SHALL equal advance, combinationally.
REQ-020 Latency with no stall SHALL be STAGES cycles: accepted at edge T gives out_valid=1 after edge T+STAGES-1, i.e. STAGES cycles after acceptance when STAGES=1 counts as 1.
REQ-021 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-022 A cycle with in_valid=0 and advance=1 SHALL insert a bubble: per-stage valid bit 0; bubbles are not collapsed.
REQ-023 While out_valid=1 and out_ready=0, sum, c_out, out_valid (and ovf) SHALL be held stable.
REQ-024 Results SHALL emerge in acceptance order; none dropped, none duplicated.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH with {c_out,sum} = a+b+c exactly (WIDTH+1-bit result).
REQ-026 Operand values while in_valid=0 SHALL NOT affect any output.

Reset
REQ-027 On rst_n=0, asynchronously, all per-stage valid bits, out_valid, sum, c_out and ovf SHALL clear to 0; in_ready therefore reads 1.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; first acceptance is possible on the first rising edge with rst_n=1.
REQ-029 Reset deassertion requires no extra idle cycles.

Configuration
REQ-030 With macro PIPE_ADDER_OVF_EN defined, port ovf SHALL exist and equal (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), carried through the pipeline aligned with its result; ovf is 0 whenever out_valid=0.
REQ-031 Without PIPE_ADDER_OVF_EN, port ovf and its pipeline register SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-032 a=0xFFFF, b=0x0001, c=0 accepted at edge T -> out_valid=1 after edge T+3 with sum=0x0000, c_out=1 (full carry ripple across all slices).
REQ-033 a=0xFFFF, b=0xFFFF, c=1 -> sum=0xFFFF, c_out=1; a=0x0000, b=0x0000, c=0 -> sum=0x0000, c_out=0.
REQ-034 8 back-to-back ops a=i, b=2i, c=i[0] for i=0..7 -> 8 consecutive out_valid cycles with sum=3i+i[0] in order.
REQ-035 Hold out_ready=0 for 6 cycles with pipeline full -> in_ready=0, output stable; release -> remaining results in order, none lost.
REQ-036 Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately, in_ready=1; no stale result appears after release.
REQ-037 With PIPE_ADDER_OVF_EN: 0x7FFF+0x0001, c=0 -> sum=0x8000, ovf=1; 0x8000+0xFFFF -> sum=0x7FFF, c_out=1, ovf=1; 0x0001+0x0001 -> ovf=0.
